// File: rtl/edge_pkg.sv
// Shared types and defaults for the edge-detection pipeline.
package edge_pkg;

  localparam int DEF_WIDTH  = 720;
  localparam int DEF_HEIGHT = 540;

  typedef logic [7:0] pix_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/raster_counter.sv
// Row/column raster position with wrap at the frame end and a last-pixel flag.
// Latency 0 (registered position, combinational flag); advances only on i_inc.
module raster_counter
  import edge_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int CW     = $clog2(WIDTH),
  parameter int RW     = $clog2(HEIGHT)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [RW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_last
);

  localparam logic [CW-1:0] LAST_C = CW'(WIDTH - 1);
  localparam logic [RW-1:0] LAST_R = RW'(HEIGHT - 1);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          w_last_col;

  assign w_last_col = (r_col == LAST_C);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_inc) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= (r_row == LAST_R) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_last = w_last_col && (r_row == LAST_R);

endmodule

// File: rtl/sobel_stream_ctrl.sv
// Sobel stage sequencer: pops gray pixels, drives window shift, emits WIDTH*HEIGHT results per frame.
// Optional SOBEL_CTRL_STATS_EN adds frame_count/stall_count; a full output FIFO freezes the window.
module sobel_stream_ctrl
  import edge_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int CW     = $clog2(WIDTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_empty,
  output logic          in_rd_en,
  input  pix_t          in_dout,
  output logic          shift_en,
  output pix_t          shift_px,
  output logic [CW-1:0] lb_addr,
  input  pix_t          sobel_mag,
  input  logic          out_full,
  output logic          out_wr_en,
  output pix_t          out_din,
  output logic          frame_done
`ifdef SOBEL_CTRL_STATS_EN
  ,
  output logic [31:0]   frame_count,
  output logic [31:0]   stall_count
`endif
);

  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] LAST_C = CW'(WIDTH - 1);
  localparam logic [RW-1:0] LAST_R = RW'(HEIGHT - 1);

  state_t        r_state;
  logic          r_pend;
  logic          r_frame_done;

  logic [RW-1:0] w_in_row;
  logic [CW-1:0] w_in_col;
  logic          w_in_last;
  logic [RW-1:0] w_out_row;
  logic [CW-1:0] w_out_col;
  logic          w_out_last;

  logic          w_slot;
  logic          w_emit;
  logic          w_adv;
  logic          w_in_at_w;
  logic          w_flush_end;
  logic          w_border;
  logic          w_frame_end;

  assign w_slot = !r_pend || !out_full;
  assign w_emit = r_pend && !out_full;

  // Input position k==WIDTH is the (WIDTH+1)th advance; k==WIDTH+1 after the wrap ends the flush.
  assign w_in_at_w   = (w_in_row == RW'(1)) && (w_in_col == '0);
  assign w_flush_end = (w_in_row == RW'(1)) && (w_in_col == CW'(1));

  always_comb begin
    w_adv = 1'b0;
    unique case (r_state)
      FILL:    w_adv = !in_empty;
      RUN:     w_adv = !in_empty && w_slot;
      FLUSH:   w_adv = w_slot && !w_flush_end;
      default: w_adv = 1'b0;
    endcase
    // Keep the FIFO and datapath quiet while reset is held.
    w_adv = w_adv && reset;
  end

  assign w_border    = (w_out_row == '0) || (w_out_row == LAST_R) ||
                       (w_out_col == '0) || (w_out_col == LAST_C);
  assign w_frame_end = w_emit && w_out_last && (r_state == FLUSH);

  assign in_rd_en   = w_adv && (r_state != FLUSH);
  assign shift_en   = w_adv;
  assign shift_px   = (r_state == FLUSH) ? '0 : in_dout;
  assign lb_addr    = w_in_col;
  assign out_wr_en  = w_emit;
  assign out_din    = (r_pend && !w_border) ? sobel_mag : '0;
  assign frame_done = r_frame_done;

  raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_in_pos (
    .clock  (clock),
    .reset  (reset),
    .i_clr  (w_frame_end),
    .i_inc  (w_adv),
    .o_row  (w_in_row),
    .o_col  (w_in_col),
    .o_last (w_in_last)
  );

  raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_out_pos (
    .clock  (clock),
    .reset  (reset),
    .i_clr  (w_frame_end),
    .i_inc  (w_emit),
    .o_row  (w_out_row),
    .o_col  (w_out_col),
    .o_last (w_out_last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= FILL;
      r_pend       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_adv && (r_state != FILL)) begin
        r_pend <= 1'b1;
      end else if (w_emit) begin
        r_pend <= 1'b0;
      end
      unique case (r_state)
        FILL:    if (w_adv && w_in_at_w) r_state <= RUN;
        RUN:     if (w_adv && w_in_last) r_state <= FLUSH;
        FLUSH:   if (w_frame_end) r_state <= FILL;
        default: r_state <= FILL;
      endcase
    end
  end

`ifdef SOBEL_CTRL_STATS_EN
  logic [31:0] r_frame_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_frame_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_frame_end) begin
        r_frame_count <= r_frame_count + 32'd1;
        r_stall_count <= '0;
      end else if (r_pend && out_full) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign frame_count = r_frame_count;
  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Randomized bench for sobel_stream_ctrl on a 4x3 frame with a window stub echoing the last shifted pixel.
module tb_sobel_stream_ctrl;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_empty;
  logic       in_rd_en;
  logic [7:0] in_dout;
  logic       shift_en;
  logic [7:0] shift_px;
  logic [1:0] lb_addr;
  logic [7:0] sobel_mag;
  logic       out_full;
  logic       out_wr_en;
  logic [7:0] out_din;
  logic       frame_done;
`ifdef SOBEL_CTRL_STATS_EN
  logic [31:0] frame_count;
  logic [31:0] stall_count;
`endif

  logic [7:0]   r_win;
  int           checks = 0;
  int           errors = 0;
  byte unsigned src_q[$];
  logic [7:0]   cur_px [N];
  int           pops, advs, emits, done_seen, stall_m;
  bit           exp_done;

  sobel_stream_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_empty   (in_empty),
    .in_rd_en   (in_rd_en),
    .in_dout    (in_dout),
    .shift_en   (shift_en),
    .shift_px   (shift_px),
    .lb_addr    (lb_addr),
    .sobel_mag  (sobel_mag),
    .out_full   (out_full),
    .out_wr_en  (out_wr_en),
    .out_din    (out_din),
    .frame_done (frame_done)
`ifdef SOBEL_CTRL_STATS_EN
    ,
    .frame_count(frame_count),
    .stall_count(stall_count)
`endif
  );

  always #5 clock = ~clock;

  // Window stub: the magnitude is the most recently shifted pixel, exposing alignment errors.
  always @(posedge clock or negedge reset) begin
    if (!reset) r_win <= 8'h00;
    else if (shift_en) r_win <= shift_px;
  end
  assign sobel_mag = r_win;

  function automatic bit is_border(input int n);
    return (n / W == 0) || (n / W == H - 1) || (n % W == 0) || (n % W == W - 1);
  endfunction

  task automatic clear_model();
    pops = 0; advs = 0; emits = 0; exp_done = 0; stall_m = 0;
    src_q.delete();
  endtask

  // One clock of stimulus plus the reference model of what the controller must do this cycle.
  task automatic step(input bit emp_req, input bit full_req);
    bit pend_m, exp_rd, exp_sh, exp_wr;
    logic [7:0] exp_px;
    @(negedge clock);
    in_empty = emp_req || (src_q.size() == 0);
    in_dout  = (src_q.size() != 0) ? src_q[0] : 8'h00;
    out_full = full_req;
    #1;
    checks++;
    if (frame_done !== exp_done) begin
      errors++; $display("FAIL frame_done got %b want %b", frame_done, exp_done);
    end
    if (exp_done) begin
      done_seen++; pops = 0; advs = 0; emits = 0; exp_done = 0;
`ifdef SOBEL_CTRL_STATS_EN
      checks++;
      if (frame_count !== 32'(done_seen)) begin
        errors++; $display("FAIL frame_count got %0d want %0d", frame_count, done_seen);
      end
`endif
    end
    // Advances beyond the first W+1 each leave one result; pending = left minus emitted.
    pend_m = (advs > W + 1 + emits);
    exp_rd = !in_empty && (pops < N) && ((advs < W + 1) || !pend_m || !out_full);
    exp_sh = exp_rd || ((pops == N) && (advs < N + W + 1) && (!pend_m || !out_full));
    exp_wr = pend_m && !out_full;
    checks += 3;
    if (in_rd_en !== exp_rd) begin
      errors++; $display("FAIL in_rd_en got %b want %b (pops %0d)", in_rd_en, exp_rd, pops);
    end
    if (shift_en !== exp_sh) begin
      errors++; $display("FAIL shift_en got %b want %b (advs %0d)", shift_en, exp_sh, advs);
    end
    if (out_wr_en !== exp_wr) begin
      errors++; $display("FAIL out_wr_en got %b want %b (emits %0d)", out_wr_en, exp_wr, emits);
    end
    if (pend_m && out_full) stall_m++;
    if (exp_wr) begin
      if (is_border(emits)) exp_px = 8'h00;
      else exp_px = cur_px[emits + W + 1];
      checks++;
      if (out_din !== exp_px) begin
        errors++; $display("FAIL out_din[%0d] got %h want %h", emits, out_din, exp_px);
      end
`ifdef SOBEL_CTRL_STATS_EN
      if (emits == N - 1) begin
        checks++;
        if (stall_count !== 32'(stall_m)) begin
          errors++; $display("FAIL stall_count got %0d want %0d", stall_count, stall_m);
        end
        stall_m = 0;
      end
`endif
      emits++;
      if (emits == N) exp_done = 1;
    end
    if (exp_sh) begin
      if (exp_rd) begin
        checks += 2;
        if (lb_addr !== 2'(pops % W)) begin
          errors++; $display("FAIL lb_addr got %0d want %0d", lb_addr, pops % W);
        end
        if (shift_px !== src_q[0]) begin
          errors++; $display("FAIL shift_px got %h want %h", shift_px, src_q[0]);
        end
        cur_px[pops] = src_q.pop_front();
        pops++;
      end else begin
        checks++;
        if (shift_px !== 8'h00) begin
          errors++; $display("FAIL flush shift_px got %h want 00", shift_px);
        end
      end
      advs++;
    end
  endtask

  // mode 0 clean, 1 five-cycle full, 2 empty every other cycle, 3 random, 4 three-cycle full.
  task automatic run_frames(input int nfr, input int mode, input int stop_pops);
    int target, full_left;
    bit full_used, e, f;
    target = done_seen + nfr; full_left = 0; full_used = 0;
    repeat (nfr * N) src_q.push_back(8'($urandom_range(1, 255)));
    for (int cyc = 0; cyc < 300 * nfr; cyc++) begin
      if (stop_pops > 0 && pops >= stop_pops) return;
      e = 0; f = 0;
      if ((mode == 1 || mode == 4) && !full_used && pops == 8) begin
        full_left = (mode == 1) ? 5 : 3; full_used = 1;
      end
      if (mode == 2) e = (cyc % 2) == 1;
      if (mode == 3) begin
        e = ($urandom_range(0, 3) == 0);
        f = ($urandom_range(0, 2) == 0);
      end
      if (full_left > 0) begin f = 1; full_left--; end
      step(e, f);
      if (done_seen == target) return;
    end
    checks++; errors++;
    $display("FAIL timeout mode %0d done %0d want %0d", mode, done_seen, target);
  endtask

  task automatic check_quiet(input string tag);
    checks++;
    if ({in_rd_en, shift_en, out_wr_en, frame_done} !== 4'b0 || out_din !== 8'h00 || lb_addr !== 2'd0) begin
      errors++;
      $display("FAIL %s outputs rd %b sh %b wr %b fd %b din %h addr %0d want all 0",
               tag, in_rd_en, shift_en, out_wr_en, frame_done, out_din, lb_addr);
    end
  endtask

  task automatic release_reset();
    in_empty = 1; out_full = 0;
    @(negedge clock);
    reset = 1;
    clear_model();
  endtask

  task automatic test_reset();
    reset = 0; in_empty = 0; in_dout = 8'hAA; out_full = 0;
    repeat (2) @(negedge clock);
    #1 check_quiet("reset");
    release_reset();
  endtask

  task automatic test_basic();
    int d0 = done_seen;
    run_frames(1, 0, 0);
    checks++;
    if (done_seen !== d0 + 1) begin
      errors++; $display("FAIL basic frames got %0d want %0d", done_seen - d0, 1);
    end
  endtask

  task automatic test_full_stall();   run_frames(1, 1, 0); endtask
  task automatic test_empty_toggle(); run_frames(1, 2, 0); endtask
  task automatic test_random();       run_frames(3, 3, 0); endtask

  task automatic test_back_to_back();
    int d0 = done_seen;
    run_frames(2, 0, 0);
    checks++;
    if (done_seen !== d0 + 2) begin
      errors++; $display("FAIL b2b frames got %0d want %0d", done_seen - d0, 2);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    run_frames(1, 0, 7);
    @(negedge clock);
    in_empty = 0;
    reset = 0;
    #1 check_quiet("mid_reset");
    @(negedge clock);
    #1 check_quiet("mid_reset_hold");
    release_reset();
    d0 = done_seen;
    run_frames(1, 0, 0);
    checks++;
    if (done_seen !== d0 + 1) begin
      errors++; $display("FAIL post_reset frames got %0d want %0d", done_seen - d0, 1);
    end
  endtask

`ifdef SOBEL_CTRL_STATS_EN
  task automatic test_stats(); run_frames(1, 4, 0); endtask
`endif

  initial begin
    done_seen = 0;
    clear_model();
    test_reset();
    test_basic();
    test_full_stall();
    test_empty_toggle();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef SOBEL_CTRL_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_stream_ctrl.md
# sobel_stream_ctrl

Sequencing controller for the Sobel stage of the edge-detection pipeline, placed between the grayscale FIFO and the output FIFO. It pops one grayscale pixel per advance and drives the 3x3 window/line-buffer shift and line-buffer address. It tracks input and output raster position, forces border outputs to zero, and emits exactly WIDTH*HEIGHT results per frame, including the end-of-frame flush.

## Interface
- WIDTH, 720, pixels per row (>= 3)
- HEIGHT, 540, rows per frame (>= 3)
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-low
- in_empty  in  1  grayscale FIFO empty
- in_rd_en  out  1  pop grayscale FIFO (combinational)
- in_dout  in  8  grayscale pixel at FIFO head
- shift_en  out  1  datapath: shift window and line buffers by one pixel
- shift_px  out  8  pixel to shift in: in_dout while consuming, 0 during flush
- lb_addr  out  $clog2(WIDTH)  line-buffer column address (input column)
- sobel_mag  in  8  datapath magnitude of the current (registered) window
- out_full  in  1  output FIFO full
- out_wr_en  out  1  push output FIFO (combinational)
- out_din  out  8  result pixel
- frame_done  out  1  one-cycle pulse, registered, after the last output of a frame

## Operation
- States: FILL, RUN, FLUSH.
- Reset state FILL. Counters cleared.
- Output reset values: in_rd_en 0, shift_en 0, out_wr_en 0, out_din 0, lb_addr 0, frame_done 0.
- Input counter k counts 0..WIDTH*HEIGHT-1 pixels consumed. lb_addr = k mod WIDTH.
- pend: one-entry flag meaning the window holds an unemitted result.
  - Emit = pend && !out_full.
  - out_din = border ? 0 : sobel_mag.
- Output position (orow, ocol) advances on each emit.
  - border = orow==0 || orow==HEIGHT-1 || ocol==0 || ocol==WIDTH-1.
- slot = !pend || !out_full.
- FILL: advance = !in_empty.
  - First WIDTH+1 advances set no pend.
  - After advance WIDTH+1 completes, go to RUN.
- RUN: advance = !in_empty && slot. Each advance sets pend for the following cycle.
  - When k reaches WIDTH*HEIGHT, go to FLUSH.
- FLUSH: advance = slot, in_rd_en = 0, shift_px = 0.
  - Exactly WIDTH+1 flush advances, each setting pend.
  - After the final emit, pulse frame_done, clear all counters, go to FILL.
- Advance asserts shift_en. In FILL and RUN it also asserts in_rd_en in the same cycle.
- Next-frame pixels are never consumed before frame_done.

## Timing
- Advance in cycle t → window valid in t+1 → sobel_mag sampled combinationally → emit no earlier than t+1.
- Steady-state throughput: 1 pixel/cycle, with simultaneous emit and advance in the same cycle.
- Latency from first pop to first emit: WIDTH+1 advances plus 1 cycle.
- out_full held: pend stays set and no advance occurs. Input stalls and the window is frozen; shift_en is 0.
- in_empty in RUN: pend drains and no new pend is set.
- Frame of WIDTH*HEIGHT inputs produces exactly WIDTH*HEIGHT emits.
- Reset mid-frame: immediate return to FILL, pend cleared, partial frame discarded, no frame_done.

## Configuration
- SOBEL_CTRL_STATS_EN defined: adds two outputs.
  - frame_count[31:0]: increments on frame_done.
  - stall_count[31:0]: counts cycles with pend && out_full. Cleared on frame_done.
  - Both reset to 0.
- SOBEL_CTRL_STATS_EN undefined: neither port nor any counter logic exists.

## Structure
- Shared package edge_pkg holds:
  - state enum (FILL, RUN, FLUSH)
  - default WIDTH/HEIGHT constants
  - pixel width typedef (8-bit gray)
- Sub-module raster_counter (row/col with wrap and last-pixel flag), instantiated twice: input side and output side.

## Test plan
- WIDTH=4, HEIGHT=3, ramp input 0..11, out_full=0, sobel_mag stub = 0x55.
  - Outputs 12 pixels: 0 at all border positions, 0x55 at (1,1) and (1,2).
  - frame_done one pulse after the 12th emit.
- Same frame, out_full held high 5 cycles mid-RUN: no pops and no shift_en while full, pend held, identical output sequence.
- in_empty toggled every other cycle: 12 outputs in order; in_rd_en never asserted while in_empty=1.
- Two back-to-back frames: 24 outputs, two frame_done pulses.
  - The second frame's first pop does not occur before the first frame_done.
- Reset asserted after 7 pops: all outputs 0 immediately. A subsequent clean frame yields the correct 12 outputs.
- With SOBEL_CTRL_STATS_EN, 3-cycle out_full stall: stall_count=3 before frame_done, frame_count=1 after.
